timer_pwm_ctrl: RTL and testbench

Configuration and sequencing controller for the timer/PWM datapath.
- Accepts register writes from the bus side into shadow registers.
- Generates the timer tick from the selected source: prescaled CPU clock or synchronised GPIO edge.
- Tracks the period and commits shadow values glitch-free at a period boundary.
- On a mode or source change, holds the datapath in reset for a few cycles before resynchronising.
- Sits between the CPU register bus and the datapath ports TMR_SRC, TMR_MODE, TIMER_TOP, PWM_CNTA and PWM_CNTB.

---
 rtl/timer_pwm_ctrl_pkg.sv | 52 +++++
 rtl/timer_pwm_ctrl_if.sv | 31 +++
 rtl/timer_pwm_ctrl_tick_gen.sv | 68 ++++++
 rtl/timer_pwm_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_timer_pwm_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pwm_pkg
// Description : Shared constants and types for the timer/PWM controller:
//               register map, tick source / mode encodings, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pwm_pkg;

    // Register map of the configuration bus
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_TOP    = 3'd1;
    localparam logic [2:0] ADDR_CNTA   = 3'd2;
    localparam logic [2:0] ADDR_CNTB   = 3'd3;
    localparam logic [2:0] ADDR_PRESC  = 3'd4;
    localparam logic [2:0] ADDR_COMMIT = 3'd5;

    // Tick source selection
    typedef enum logic [1:0] {
        SRC_OFF  = 2'b00,
        SRC_CLK  = 2'b01,
        SRC_GPIO = 2'b10
    } src_t;

    // Datapath operating mode
    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_FAST   = 2'b01,
        MODE_PHASE  = 2'b10
    } mode_t;

    // Commit sequencer states
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        PEND   = 2'b01,
        RESYNC = 2'b10
    } state_t;

    // A commit needs a datapath resync when source or mode changes, or when
    // the timer is disabled (no period end would ever arrive to commit on).
    function automatic logic needs_resync(
        input logic [1:0] sh_src,
        input logic [1:0] sh_mode,
        input logic [1:0] act_src,
        input logic [1:0] act_mode
    );
        return (sh_src != act_src) || (sh_mode != act_mode) ||
               (act_src == SRC_OFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_pwm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_pwm_ctrl_if
// Description : CPU-side configuration write channel (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_pwm_ctrl_if;

    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;

    // Bus side issuing writes
    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_ready
    );

    // Controller side accepting writes
    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/timer_pwm_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : timer_tick_gen
// Description : Timer tick source: CPU-clock prescaler or synchronised GPIO
//               rising edge. The tick output is combinational so the parent
//               can register the tick and the period compare in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_tick_gen
    import timer_pwm_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [1:0]         src,
    input  wire logic [PRESC_W-1:0] presc,
    input  wire logic               clr,
    input  wire logic               gpio_in,
    output logic                    tick
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               sync1;
    logic               sync2;
    logic               edge_q;
    logic               presc_wrap;

    assign presc_wrap = (presc_cnt == presc);

    // Prescaler counts 0..presc, held at zero whenever it is not the source
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt <= '0;
        end else if (clr || (src != SRC_CLK) || presc_wrap) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous pin plus the edge history flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= gpio_in;
            sync2  <= sync1;
            edge_q <= clr ? 1'b0 : sync2;
        end
    end

    // Source mux; everything is silenced while the datapath is resyncing
    always_comb begin
        tick = 1'b0;
        if (!clr) begin
            case (src)
                SRC_CLK:  tick = presc_wrap;
                SRC_GPIO: tick = sync2 & ~edge_q;
                default:  tick = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timer_pwm_ctrl
// Description : Configuration and sequencing controller for the timer/PWM
//               datapath. Bus writes land in shadow registers; a COMMIT
//               either applies them at the next period end (same source and
//               mode) or through a short datapath reset (resync).
// Revision    : 1.0 - initial release
// ============================================================================
module timer_pwm_ctrl
    import timer_pwm_pkg::*;
#(
    parameter logic [31:0] TOP_RST    = 32'h0000FFFF,
    parameter int          PRESC_W    = 16,
    parameter int          RST_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    timer_pwm_ctrl_if.slave  cfg,
    input  wire logic        gpio_in,
    output logic [1:0]       TMR_SRC,
    output logic [1:0]       TMR_MODE,
    output logic [31:0]      TIMER_TOP,
    output logic [31:0]      PWM_CNTA,
    output logic [31:0]      PWM_CNTB,
    output logic             dp_reset,
    output logic             tmr_tick,
    output logic             update_evt,
    output logic             busy
);

    localparam int RS_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RS_W-1:0] RS_LAST = RS_W'(RST_CYCLES - 1);

    state_t             state;
    state_t             next_state;

    logic [1:0]         sh_src;
    logic [1:0]         sh_mode;
    logic [31:0]        sh_top;
    logic [31:0]        sh_cnta;
    logic [31:0]        sh_cntb;
    logic [PRESC_W-1:0] sh_presc;
    logic [PRESC_W-1:0] act_presc;

    logic [31:0]        period_cnt;
    logic [RS_W-1:0]    rs_cnt;

    logic               wr_en;
    logic               commit_req;
    logic               need_resync;
    logic               rs_done;
    logic               enter_resync;
    logic               resync_go;
    logic               pend_commit;
    logic               tick_raw;

    assign wr_en        = cfg.cfg_valid && cfg.cfg_ready;
    assign commit_req   = wr_en && (cfg.cfg_addr == ADDR_COMMIT);
    assign need_resync  = needs_resync(sh_src, sh_mode, TMR_SRC, TMR_MODE);
    assign rs_done      = (rs_cnt == RS_LAST);
    assign enter_resync = (state == PEND) && need_resync;
    // High on the entry edge and every resync cycle except the last one;
    // drives dp_reset, tick suppression and counter clearing.
    assign resync_go    = enter_resync || ((state == RESYNC) && !rs_done);
    assign pend_commit  = (state == PEND) && !need_resync && update_evt;

    timer_tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .src     (TMR_SRC),
        .presc   (act_presc),
        .clr     (resync_go),
        .gpio_in (gpio_in),
        .tick    (tick_raw)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (commit_req) begin
                    next_state = PEND;
                end
            end
            PEND: begin
                if (need_resync) begin
                    next_state = RESYNC;
                end else if (update_evt) begin
                    next_state = RUN;
                end
            end
            RESYNC: begin
                if (rs_done) begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // Shadow registers written from the bus (COMMIT and 6-7 store nothing)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_src   <= SRC_OFF;
            sh_mode  <= MODE_NORMAL;
            sh_top   <= TOP_RST;
            sh_cnta  <= '0;
            sh_cntb  <= '0;
            sh_presc <= '0;
        end else if (wr_en) begin
            case (cfg.cfg_addr)
                ADDR_CTRL: begin
                    sh_src  <= cfg.cfg_wdata[1:0];
                    sh_mode <= cfg.cfg_wdata[3:2];
                end
                ADDR_TOP:   sh_top   <= cfg.cfg_wdata;
                ADDR_CNTA:  sh_cnta  <= cfg.cfg_wdata;
                ADDR_CNTB:  sh_cntb  <= cfg.cfg_wdata;
                ADDR_PRESC: sh_presc <= cfg.cfg_wdata[PRESC_W-1:0];
                default: ;
            endcase
        end
    end

    // Active registers: full load on resync, compare values only at period end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            TMR_SRC   <= SRC_OFF;
            TMR_MODE  <= MODE_NORMAL;
            TIMER_TOP <= TOP_RST;
            PWM_CNTA  <= '0;
            PWM_CNTB  <= '0;
            act_presc <= '0;
        end else if (enter_resync) begin
            TMR_SRC   <= sh_src;
            TMR_MODE  <= sh_mode;
            TIMER_TOP <= sh_top;
            PWM_CNTA  <= sh_cnta;
            PWM_CNTB  <= sh_cntb;
            act_presc <= sh_presc;
        end else if (pend_commit) begin
            TIMER_TOP <= sh_top;
            PWM_CNTA  <= sh_cnta;
            PWM_CNTB  <= sh_cntb;
        end
    end

    // Resync length counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_cnt <= '0;
        end else if (enter_resync) begin
            rs_cnt <= '0;
        end else if ((state == RESYNC) && !rs_done) begin
            rs_cnt <= rs_cnt + RS_W'(1);
        end
    end

    // Period tracker; tick and period-end pulses registered together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
            tmr_tick   <= 1'b0;
            update_evt <= 1'b0;
        end else if (resync_go) begin
            period_cnt <= '0;
            tmr_tick   <= 1'b0;
            update_evt <= 1'b0;
        end else begin
            tmr_tick   <= tick_raw;
            update_evt <= tick_raw && (period_cnt == TIMER_TOP);
            if (tick_raw) begin
                period_cnt <= (period_cnt == TIMER_TOP) ? 32'd0
                                                        : period_cnt + 32'd1;
            end
        end
    end

    // Status outputs follow the state being entered so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy          <= 1'b0;
            cfg.cfg_ready <= 1'b1;
            dp_reset      <= 1'b0;
        end else begin
            busy          <= (next_state != RUN);
            cfg.cfg_ready <= (next_state == RUN);
            dp_reset      <= resync_go;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_pwm_ctrl
// Description : Self-checking bench for timer_pwm_ctrl: per-cycle vector
//               table for the first resync and period, then directed
//               sequences for deferred commit, mode resync, GPIO ticks and
//               reset during a pending commit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_pwm_ctrl;
    import timer_pwm_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        gpio_in = 1'b0;
    logic [1:0]  TMR_SRC;
    logic [1:0]  TMR_MODE;
    logic [31:0] TIMER_TOP;
    logic [31:0] PWM_CNTA;
    logic [31:0] PWM_CNTB;
    logic        dp_reset;
    logic        tmr_tick;
    logic        update_evt;
    logic        busy;

    timer_pwm_ctrl_if cfg_if ();

    timer_pwm_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg        (cfg_if),
        .gpio_in    (gpio_in),
        .TMR_SRC    (TMR_SRC),
        .TMR_MODE   (TMR_MODE),
        .TIMER_TOP  (TIMER_TOP),
        .PWM_CNTA   (PWM_CNTA),
        .PWM_CNTB   (PWM_CNTB),
        .dp_reset   (dp_reset),
        .tmr_tick   (tmr_tick),
        .update_evt (update_evt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        valid;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic        e_tick;
        logic        e_upd;
        logic        e_dp;
        logic        e_busy;
        logic        e_ready;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_wdata = d;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic dp_seen;
        int   found;
        int   ticks;
        int   upds;
        int   first_tick;

        // Cycle-by-cycle expectations from reset: TOP=3, src CLK, COMMIT,
        // two-cycle resync, then a tick every cycle and a period end every 4.
        vecs[0]  = '{1'b1, ADDR_TOP,    32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, ADDR_CTRL,   32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, ADDR_COMMIT, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 3'd0,        32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 3'd0,        32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 3'd0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 3'd0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 3'd0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 3'd0,        32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 3'd0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 3'd0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 3'd0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 3'd0,        32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = 3'd0;
        cfg_if.cfg_wdata = 32'd0;

        // Reset values after release
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        check("rst TIMER_TOP", TIMER_TOP, 32'h0000FFFF);
        check("rst TMR_SRC", {30'd0, TMR_SRC}, 32'd0);
        check("rst TMR_MODE", {30'd0, TMR_MODE}, 32'd0);
        check("rst PWM_CNTA", PWM_CNTA, 32'd0);
        check("rst PWM_CNTB", PWM_CNTB, 32'd0);
        check("rst outs", {28'd0, dp_reset, tmr_tick, update_evt, busy}, 32'd0);
        check("rst cfg_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);

        // Vector table: first commit with resync, then period tracking
        for (int i = 0; i < 13; i++) begin
            cfg_if.cfg_valid = vecs[i].valid;
            cfg_if.cfg_addr  = vecs[i].addr;
            cfg_if.cfg_wdata = vecs[i].wdata;
            step();
            cfg_if.cfg_valid = 1'b0;
            check($sformatf("vec%0d tmr_tick", i), {31'd0, tmr_tick}, {31'd0, vecs[i].e_tick});
            check($sformatf("vec%0d update_evt", i), {31'd0, update_evt}, {31'd0, vecs[i].e_upd});
            check($sformatf("vec%0d dp_reset", i), {31'd0, dp_reset}, {31'd0, vecs[i].e_dp});
            check($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            check($sformatf("vec%0d cfg_ready", i), {31'd0, cfg_if.cfg_ready}, {31'd0, vecs[i].e_ready});
        end
        check("vec TMR_SRC", {30'd0, TMR_SRC}, 32'd1);
        check("vec TIMER_TOP", TIMER_TOP, 32'd3);

        // Load PRESC=2 and TOP=1 via two resyncs (src off, then back to CLK)
        cfg_write(ADDR_PRESC, 32'h0001_0002);
        cfg_write(ADDR_CTRL, 32'hFFFF_FFF0);
        cfg_write(ADDR_COMMIT, 32'd0);
        wait_idle("t3 idle off");
        check("t3 src off", {30'd0, TMR_SRC}, 32'd0);
        check("t3 ctrl high bits ignored", {30'd0, TMR_MODE}, 32'd0);
        cfg_write(ADDR_CTRL, 32'd1);
        cfg_write(ADDR_TOP, 32'd1);
        cfg_write(ADDR_COMMIT, 32'd0);
        wait_idle("t3 idle clk");
        check("t3 TIMER_TOP", TIMER_TOP, 32'd1);

        // Same src/mode: CNTA applied only after the next period end
        cfg_write(ADDR_CNTA, 32'd5);
        cfg_write(ADDR_COMMIT, 32'd0);
        check("t3 busy", {31'd0, busy}, 32'd1);
        check("t3 ready low", {31'd0, cfg_if.cfg_ready}, 32'd0);
        dp_seen = 1'b0;
        found   = 0;
        for (int i = 0; i < 30; i++) begin
            if (dp_reset) dp_seen = 1'b1;
            if (update_evt) begin
                found = 1;
                break;
            end
            step();
        end
        check("t3 update seen", found, 32'd1);
        check("t3 CNTA before", PWM_CNTA, 32'd0);
        check("t3 ready at evt", {31'd0, cfg_if.cfg_ready}, 32'd0);
        step();
        if (dp_reset) dp_seen = 1'b1;
        check("t3 CNTA after", PWM_CNTA, 32'd5);
        check("t3 ready after", {31'd0, cfg_if.cfg_ready}, 32'd1);
        check("t3 busy after", {31'd0, busy}, 32'd0);
        check("t3 no dp_reset", {31'd0, dp_seen}, 32'd0);

        // Mode change: one PEND cycle then two resync cycles without ticks
        cfg_write(ADDR_CTRL, 32'd5);
        cfg_write(ADDR_COMMIT, 32'd0);
        check("t4 pend busy", {31'd0, busy}, 32'd1);
        check("t4 pend dp", {31'd0, dp_reset}, 32'd0);
        step();
        check("t4 rs1 dp", {31'd0, dp_reset}, 32'd1);
        check("t4 rs1 mode", {30'd0, TMR_MODE}, 32'd1);
        check("t4 rs1 tick", {31'd0, tmr_tick}, 32'd0);
        step();
        check("t4 rs2 dp", {31'd0, dp_reset}, 32'd1);
        check("t4 rs2 tick", {31'd0, tmr_tick}, 32'd0);
        step();
        check("t4 end dp", {31'd0, dp_reset}, 32'd0);
        check("t4 end busy", {31'd0, busy}, 32'd0);

        // GPIO source with TOP=0: a 5-cycle pulse gives exactly one tick
        cfg_write(ADDR_CTRL, 32'd6);
        cfg_write(ADDR_TOP, 32'd0);
        cfg_write(ADDR_COMMIT, 32'd0);
        wait_idle("t5 idle");
        check("t5 src gpio", {30'd0, TMR_SRC}, 32'd2);
        step();
        step();
        gpio_in    = 1'b1;
        ticks      = 0;
        upds       = 0;
        first_tick = -1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) gpio_in = 1'b0;
            step();
            if (tmr_tick) begin
                ticks++;
                if (first_tick < 0) first_tick = k;
            end
            if (update_evt) upds++;
        end
        check("t5 tick count", ticks, 32'd1);
        check("t5 update count", upds, 32'd1);
        check("t5 tick latency", first_tick, 32'd3);

        // Reset during a pending commit discards the shadow write
        cfg_write(ADDR_CNTA, 32'h77);
        cfg_write(ADDR_COMMIT, 32'd0);
        step();
        step();
        check("t6 pend busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("t6 rst busy", {31'd0, busy}, 32'd0);
        check("t6 rst ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
        check("t6 rst src", {30'd0, TMR_SRC}, 32'd0);
        check("t6 rst mode", {30'd0, TMR_MODE}, 32'd0);
        check("t6 rst top", TIMER_TOP, 32'h0000FFFF);
        check("t6 rst cnta", PWM_CNTA, 32'd0);
        check("t6 rst dp", {31'd0, dp_reset}, 32'd0);
        step();
        reset = 1'b1;
        step();
        cfg_write(ADDR_COMMIT, 32'd0);
        dp_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dp_reset) dp_seen = 1'b1;
            step();
        end
        check("t6 resync seen", {31'd0, dp_seen}, 32'd1);
        check("t6 idle", {31'd0, busy}, 32'd0);
        check("t6 cnta reset val", PWM_CNTA, 32'd0);
        check("t6 top reset val", TIMER_TOP, 32'h0000FFFF);
        check("t6 src reset val", {30'd0, TMR_SRC}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
